// File: rtl/writeback_unit.sv
// Writeback queue: ALU and load results share a FIFO that drains one register-bank write per cycle.
// Optional combinational forwarding of queued values is enabled by defining WB_FORWARD_EN.
module writeback_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        write_enable,
    output logic [31:0] busy
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]  fwd_query,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_reg_q  [FIFO_DEPTH];
    logic [4:0]       fifo_reg_d  [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_enable_q, write_enable_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;

    logic             push_mem, push_alu, pop;
    logic [PTR_W-1:0] alu_wptr;

    // Ready looks only at the registered count; the alu side keeps one slot
    // spare so a simultaneous mem+alu push can never overflow.
    assign mem_ready = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    assign alu_ready = !rst && (count_q < CNT_W'(FIFO_DEPTH - 1));

    assign write_enable = write_enable_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;

    always_comb begin
        pop      = (count_q != '0);
        push_mem = mem_valid && mem_ready && (mem_reg != 5'd0);
        push_alu = alu_valid && alu_ready && (alu_reg != 5'd0);
        alu_wptr = wptr_q + PTR_W'(push_mem);

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_reg_d[i]  = fifo_reg_q[i];
            fifo_data_d[i] = fifo_data_q[i];
        end
        // mem entry goes first so it is the older of a same-cycle pair
        if (push_mem) begin
            fifo_reg_d[wptr_q]  = mem_reg;
            fifo_data_d[wptr_q] = mem_data;
        end
        if (push_alu) begin
            fifo_reg_d[alu_wptr]  = alu_reg;
            fifo_data_d[alu_wptr] = alu_data;
        end

        wptr_d  = wptr_q + PTR_W'(push_mem) + PTR_W'(push_alu);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);

        write_enable_d = pop;
        write_reg_d    = pop ? fifo_reg_q[rptr_q]  : write_reg_q;
        write_data_d   = pop ? fifo_data_q[rptr_q] : write_data_q;
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                busy[fifo_reg_q[idx]] = 1'b1;
            end
        end
        if (write_enable_q) begin
            busy[write_reg_q] = 1'b1;
        end
        busy[0] = 1'b0;
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match wins; the write port is oldest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_query != 5'd0) begin
            if (write_enable_q && (write_reg_q == fwd_query)) begin
                fwd_hit  = 1'b1;
                fwd_data = write_data_q;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx = rptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (fifo_reg_q[idx] == fwd_query)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_data_q[idx];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        fifo_reg_q  <= fifo_reg_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected writes, a negedge monitor checks them.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_reg, mem_reg, write_reg;
    logic [31:0] alu_data, mem_data, write_data;
    logic        write_enable;
    logic [31:0] busy;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_query;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] sb[$];

    writeback_unit #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .busy(busy)
`ifdef WB_FORWARD_EN
        , .fwd_query(fwd_query), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every write strobe must match the oldest expected entry.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst === 1'b0 && write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write",
                         write_reg, write_data);
            end else begin
                e = sb.pop_front();
                check("wb_reg", 32'(write_reg), 32'(e[36:32]));
                check("wb_data", write_data, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] sreg(input int n);
        return 5'((n % 31) + 1);
    endfunction

    initial begin
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0;
        alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0;
`ifdef WB_FORWARD_EN
        fwd_query = 0;
`endif
        repeat (2) step();
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_wreg", 32'(write_reg), 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_mem_ready", 32'(mem_ready), 32'd1);
        check("idle_alu_ready", 32'(alu_ready), 32'd1);
        step();

        // single push: write strobe two cycles after the handshake
        alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        sb.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid = 0;
        check("lat_we_c1", 32'(write_enable), 32'd0);
        check("lat_busy5_c1", 32'(busy[5]), 32'd1);
        step();
        check("lat_we_c2", 32'(write_enable), 32'd1);
        check("lat_reg_c2", 32'(write_reg), 32'd5);
        check("lat_data_c2", write_data, 32'hDEADBEEF);
        check("lat_busy5_c2", 32'(busy[5]), 32'd1);
        step();
        check("lat_we_c3", 32'(write_enable), 32'd0);
        check("lat_busy_c3", busy, 32'd0);
        check("hold_reg", 32'(write_reg), 32'd5);
        check("hold_data", write_data, 32'hDEADBEEF);

        // same-cycle mem and alu to reg 3: mem value first
        mem_valid = 1; mem_reg = 5'd3; mem_data = 32'd1;
        alu_valid = 1; alu_reg = 5'd3; alu_data = 32'd2;
        sb.push_back({5'd3, 32'd1});
        sb.push_back({5'd3, 32'd2});
        step();
        mem_valid = 0; alu_valid = 0;
        repeat (4) step();
        check("pair_drained", 32'(sb.size()), 32'd0);

        // reg 0 handshake enqueues nothing
        check("r0_ready", 32'(alu_ready), 32'd1);
        alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
        step();
        alu_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check("r0_we", 32'(write_enable), 32'd0);
            check("r0_busy", busy, 32'd0);
            step();
        end

        // fill as fast as possible, then stream through pointer wrap
        mem_valid = 1; mem_reg = sreg(0); mem_data = 32'hA000_0000;
        alu_valid = 1; alu_reg = sreg(1); alu_data = 32'hA000_0001;
        sb.push_back({sreg(0), 32'hA000_0000});
        sb.push_back({sreg(1), 32'hA000_0001});
        step();
        check("fill_alu_ready_c2", 32'(alu_ready), 32'd1);
        mem_reg = sreg(2); mem_data = 32'hA000_0002;
        alu_reg = sreg(3); alu_data = 32'hA000_0003;
        sb.push_back({sreg(2), 32'hA000_0002});
        sb.push_back({sreg(3), 32'hA000_0003});
        step();
        alu_valid = 0;
        check("near_full_alu_ready", 32'(alu_ready), 32'd0);
        check("near_full_mem_ready", 32'(mem_ready), 32'd1);
        for (int n = 4; n < 16; n++) begin
            check("stream_mem_ready", 32'(mem_ready), 32'd1);
            mem_reg = sreg(n); mem_data = 32'hA000_0000 + 32'(n);
            sb.push_back({sreg(n), 32'hA000_0000 + 32'(n)});
            step();
        end
        mem_valid = 0;
        repeat (6) step();
        check("stream_drained", 32'(sb.size()), 32'd0);

        // reset with entries queued discards them
        mem_valid = 1; mem_reg = 5'd10; mem_data = 32'h10;
        alu_valid = 1; alu_reg = 5'd11; alu_data = 32'h11;
        sb.push_back({5'd10, 32'h10});
        sb.push_back({5'd11, 32'h11});
        step();
        mem_reg = 5'd12; mem_data = 32'h12;
        alu_reg = 5'd13; alu_data = 32'h13;
        sb.push_back({5'd12, 32'h12});
        sb.push_back({5'd13, 32'h13});
        step();
        mem_valid = 0; alu_valid = 0;
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_we", 32'(write_enable), 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_alu_ready", 32'(alu_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("postrst_we", 32'(write_enable), 32'd0);
            check("postrst_busy", busy, 32'd0);
            step();
        end

        // fresh traffic after reset
        alu_valid = 1; alu_reg = 5'd9; alu_data = 32'h1234;
        sb.push_back({5'd9, 32'h1234});
        step();
        alu_valid = 0;
        check("postrst_busy9", 32'(busy[9]), 32'd1);
        repeat (3) step();

`ifdef WB_FORWARD_EN
        mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h10;
        alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h20;
        sb.push_back({5'd7, 32'h10});
        sb.push_back({5'd7, 32'h20});
        step();
        mem_valid = 0; alu_valid = 0;
        fwd_query = 5'd7;
        #1;
        check("fwd_hit7", 32'(fwd_hit), 32'd1);
        check("fwd_data7", fwd_data, 32'h20);
        fwd_query = 5'd9;
        #1;
        check("fwd_miss9", 32'(fwd_hit), 32'd0);
        step();
        fwd_query = 5'd7;
        #1;
        check("fwd_hit7_wp", 32'(fwd_hit), 32'd1);
        check("fwd_data7_wp", fwd_data, 32'h20);
        fwd_query = 5'd0;
        repeat (4) step();
`endif

        check("final_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
